seq_shift_add_multiplier: RTL

Parametrised, iterative unsigned shift-add multiplier. It replaces the fixed 4x3 combinational multiplier with one adder reused over QW clock cycles. Operands are loaded with a start/busy/done handshake, and the product is held in a register until the next operation completes. It sits on the datapath wherever area matters more than single-cycle latency.

---
 rtl/mult_pkg.sv | 7 +
 rtl/mult_add_step.sv | 30 +++
 rtl/seq_shift_add_multiplier.sv | 82 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM encoding and counter sizing for seq_shift_add_multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int cnt_w(input int qw);
        return $clog2(qw + 1);
    endfunction
endpackage

// File: rtl/mult_add_step.sv
// mult_add_step: one add-then-shift iteration on {carry,A,Q}; subtract on last step only when SHIFT_ADD_SIGNED_EN is defined
module mult_add_step
    import mult_pkg::*;
#(
    parameter int MW = 4,
    parameter int QW = 3
) (
    input  logic [MW+QW:0] caq_i,
    input  logic [MW-1:0]  mcand_i,
    input  logic           last_iter_i,
    output logic [MW+QW:0] caq_o
);
`ifdef SHIFT_ADD_SIGNED_EN
    localparam logic SGN = 1'b1;
`else
    localparam logic SGN = 1'b0;
`endif
    logic [MW:0] a_ext;
    logic [MW:0] m_ext;
    logic [MW:0] sum;
    logic        sub;
    // add (or subtract on the signed sign-bit step) when Q[0] is set, then shift right with sign or zero fill
    always_comb begin
        a_ext = caq_i[MW+QW:QW];
        m_ext = {SGN & mcand_i[MW-1], mcand_i};
        sub   = SGN & last_iter_i;
        sum   = !caq_i[0] ? a_ext : sub ? a_ext - m_ext : a_ext + m_ext;
        caq_o = {SGN & sum[MW], sum, caq_i[QW-1:1]};
    end
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: iterative shift-add multiplier, QW cycles per product; signed mode via SHIFT_ADD_SIGNED_EN
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int MW = 4,
    parameter int QW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MW-1:0]    m,
    input  logic [QW-1:0]    q,
    output logic             busy,
    output logic             done,
    output logic [MW+QW-1:0] P
);
    localparam int CW = cnt_w(QW);
    state_t           state_q;
    logic [MW-1:0]    mcand_q;
    logic [MW+QW:0]   caq_q;
    logic [MW+QW:0]   caq_d;
    logic [CW-1:0]    cnt_q;
    logic [MW+QW-1:0] p_q;
    logic             busy_q;
    logic             done_q;
    logic             last_iter;

    assign last_iter = cnt_q == CW'(1);

    mult_add_step #(.MW(MW), .QW(QW)) u_step (
        .caq_i      (caq_q),
        .mcand_i    (mcand_q),
        .last_iter_i(last_iter),
        .caq_o      (caq_d)
    );

    // handshake FSM: accept in IDLE, iterate QW times in RUN, pulse done for one cycle in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            caq_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= RUN;
                    mcand_q <= m;
                    caq_q   <= {1'b0, {MW{1'b0}}, q};
                    cnt_q   <= CW'(QW);
                    busy_q  <= 1'b1;
                end
                RUN: begin
                    caq_q <= caq_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_iter) begin
                        state_q <= DONE;
                        p_q     <= caq_d[MW+QW-1:0];
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;
endmodule
